// File: rtl/rsc_frame_encoder.sv
// rsc_frame_encoder: rate-1/2 RSC encoder (memory 2, feedback 7, feedforward 5) with per-frame trellis termination.
// Revision 1.0
`default_nettype none

module rsc_frame_encoder #(
   parameter int FRAME_LEN = 64
) (
   input  logic Turbo_clk,
   input  logic rst,
   input  logic frame_start,
   input  logic in_bit,
   input  logic in_valid,
   output logic in_ready,
   output logic sys,
   output logic parity,
   output logic Data_Valid,
   output logic frame_done
);

   localparam int             CNT_W    = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1,
      TAIL = 2'd2
   } state_t;

   state_t           state;
   logic             s1;
   logic             s0;
   logic [CNT_W-1:0] cnt;
   logic             tail_second;

   logic accept;
   logic fb;
   logic tail_u;

   assign accept = in_valid && in_ready;
   assign fb     = in_bit ^ s1 ^ s0;
   // Tail input cancels the feedback so the register flushes to zero in two steps.
   assign tail_u = s1 ^ s0;

   always_ff @(posedge Turbo_clk) begin
      if (rst) begin
         state       <= IDLE;
         s1          <= 1'b0;
         s0          <= 1'b0;
         cnt         <= '0;
         tail_second <= 1'b0;
         in_ready    <= 1'b0;
         sys         <= 1'b0;
         parity      <= 1'b0;
         Data_Valid  <= 1'b0;
         frame_done  <= 1'b0;
      end else begin
         Data_Valid <= 1'b0;
         frame_done <= 1'b0;
         case (state)
            IDLE: begin
               if (frame_start) begin
                  state       <= DATA;
                  s1          <= 1'b0;
                  s0          <= 1'b0;
                  cnt         <= '0;
                  tail_second <= 1'b0;
                  in_ready    <= 1'b1;
               end
            end
            DATA: begin
               if (accept) begin
                  s1         <= fb;
                  s0         <= s1;
                  sys        <= in_bit;
                  parity     <= fb ^ s0;
                  Data_Valid <= 1'b1;
                  if (cnt == LAST_IDX) begin
                     state    <= TAIL;
                     in_ready <= 1'b0;
                     cnt      <= '0;
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
            end
            TAIL: begin
               s1          <= 1'b0;
               s0          <= s1;
               sys         <= tail_u;
               parity      <= s0;
               Data_Valid  <= 1'b1;
               tail_second <= ~tail_second;
               if (tail_second) begin
                  state      <= IDLE;
                  frame_done <= 1'b1;
               end
            end
            default: begin
               state    <= IDLE;
               in_ready <= 1'b0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_rsc_frame_encoder.sv
// tb_rsc_frame_encoder: directed and reference-model checks for rsc_frame_encoder (FRAME_LEN 4 and 64).
// Revision 1.0
`default_nettype none

module tb_rsc_frame_encoder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;
   logic fs4, b4, v4, rdy4, sys4, par4, dv4, fd4;
   logic fs64, b64, v64, rdy64, sys64, par64, dv64, fd64;

   int passed = 0;
   int total  = 0;

   // results of the most recent run4 call
   int          n4, fdn4, fdidx4, low4, rdybad4, extra4;
   logic [11:0] seq4;
   bit          to4;

   rsc_frame_encoder #(.FRAME_LEN(4)) dut4 (
      .Turbo_clk(clk), .rst(rst), .frame_start(fs4), .in_bit(b4), .in_valid(v4),
      .in_ready(rdy4), .sys(sys4), .parity(par4), .Data_Valid(dv4), .frame_done(fd4)
   );

   rsc_frame_encoder #(.FRAME_LEN(64)) dut64 (
      .Turbo_clk(clk), .rst(rst), .frame_start(fs64), .in_bit(b64), .in_valid(v64),
      .in_ready(rdy64), .sys(sys64), .parity(par64), .Data_Valid(dv64), .frame_done(fd64)
   );

   task automatic cyc;
      @(posedge clk);
      #1;
   endtask

   // Runs one FRAME_LEN=4 frame; bits[3] is sent first. Optional gap after gp accepts,
   // optional noise (frame_start pulses, in_valid outside DATA).
   task automatic run4(input logic [3:0] bits, input int gp, input int gl, input bit noise);
      int  sent, gapc, cn;
      bit  done;
      n4 = 0; fdn4 = 0; fdidx4 = -1; low4 = 0; rdybad4 = 0; extra4 = 0; seq4 = '0; to4 = 0;
      fs4 = 1'b1; v4 = 1'b0; cyc; fs4 = 1'b0;
      sent = 0; gapc = 0; cn = 0; done = 0;
      while (!done && cn < 40) begin
         fs4 = noise && (cn % 2 == 1);
         if (sent < 4 && sent == gp && gapc < gl) begin
            v4 = 1'b0; gapc++;
         end else if (sent < 4) begin
            v4 = 1'b1; b4 = bits[3-sent];
         end else begin
            v4 = noise; b4 = 1'b1;
         end
         if (sent < 4) begin
            if (!rdy4) rdybad4++;
            else if (v4) sent++;
         end
         cyc; cn++;
         if (dv4) begin
            seq4 = {seq4[9:0], sys4, par4};
            n4++;
         end else if (n4 > 0) begin
            low4++;
         end
         if (fd4) begin
            fdn4++; fdidx4 = n4; done = 1;
         end
      end
      if (!done) to4 = 1;
      fs4 = 1'b0; v4 = 1'b0;
      repeat (3) begin
         v4 = noise;
         cyc;
         if (dv4 || fd4 || rdy4) extra4++;
      end
      v4 = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1; fs4 = 1'b1; v4 = 1'b1; b4 = 1'b1; fs64 = 1'b1; v64 = 1'b1; b64 = 1'b1;
      cyc; cyc;
      total++; if ({rdy4, sys4, par4, dv4, fd4} !== 5'b0) $display("FAIL reset4_outputs: got %b want 00000", {rdy4, sys4, par4, dv4, fd4}); else passed++;
      total++; if ({rdy64, sys64, par64, dv64, fd64} !== 5'b0) $display("FAIL reset64_outputs: got %b want 00000", {rdy64, sys64, par64, dv64, fd64}); else passed++;
      total++; if ({dut4.s1, dut4.s0} !== 2'b00) $display("FAIL reset4_state: got %b want 00", {dut4.s1, dut4.s0}); else passed++;
      rst = 1'b0; fs4 = 1'b0; fs64 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cyc;
         total++; if ({rdy4, dv4, rdy64, dv64} !== 4'b0) $display("FAIL idle_after_reset cycle %0d: got %b want 0000", i, {rdy4, dv4, rdy64, dv64}); else passed++;
      end
      v4 = 1'b0; v64 = 1'b0;
   endtask

   task automatic check_frame4(input string name, input logic [11:0] exp_seq, input int exp_low);
      total++; if (to4) $display("FAIL %s_timeout: got no frame_done want frame_done", name); else passed++;
      total++; if (n4 !== 6) $display("FAIL %s_count: got %0d want 6", name, n4); else passed++;
      total++; if (seq4 !== exp_seq) $display("FAIL %s_symbols: got %b want %b", name, seq4, exp_seq); else passed++;
      total++; if (fdn4 !== 1 || fdidx4 !== 6) $display("FAIL %s_frame_done: got %0d pulses at symbol %0d want 1 at 6", name, fdn4, fdidx4); else passed++;
      total++; if (low4 !== exp_low) $display("FAIL %s_dv_gap: got %0d want %0d", name, low4, exp_low); else passed++;
      total++; if (rdybad4 !== 0) $display("FAIL %s_in_ready: got %0d low cycles want 0", name, rdybad4); else passed++;
      total++; if (extra4 !== 0) $display("FAIL %s_after_frame: got %0d stray cycles want 0", name, extra4); else passed++;
      total++; if ({dut4.s1, dut4.s0} !== 2'b00) $display("FAIL %s_end_state: got %b want 00", name, {dut4.s1, dut4.s0}); else passed++;
   endtask

   task automatic test_basic;
      run4(4'b1011, -1, 0, 1'b0);
      check_frame4("basic", 12'b11_01_10_10_01_11, 0);
   endtask

   task automatic test_gap;
      run4(4'b1011, 2, 3, 1'b0);
      check_frame4("gap", 12'b11_01_10_10_01_11, 3);
   endtask

   task automatic test_zero;
      run4(4'b0000, -1, 0, 1'b0);
      check_frame4("zero", 12'b00_00_00_00_00_00, 0);
   endtask

   task automatic test_mid_reset;
      int bad;
      fs4 = 1'b1; cyc; fs4 = 1'b0;
      v4 = 1'b1; b4 = 1'b1; cyc;
      b4 = 1'b0; cyc;
      total++; if ({dv4, sys4, par4} !== 3'b101) $display("FAIL midrst_second_symbol: got %b want 101", {dv4, sys4, par4}); else passed++;
      rst = 1'b1; b4 = 1'b1; cyc;
      total++; if ({rdy4, sys4, par4, dv4, fd4, dut4.s1, dut4.s0} !== 7'b0) $display("FAIL midrst_outputs: got %b want 0000000", {rdy4, sys4, par4, dv4, fd4, dut4.s1, dut4.s0}); else passed++;
      rst = 1'b0; bad = 0;
      repeat (4) begin
         cyc;
         if (rdy4 || dv4 || fd4) bad++;
      end
      v4 = 1'b0;
      total++; if (bad !== 0) $display("FAIL midrst_stays_idle: got %0d active cycles want 0", bad); else passed++;
      run4(4'b1011, -1, 0, 1'b0);
      check_frame4("midrst_fresh", 12'b11_01_10_10_01_11, 0);
   endtask

   task automatic test_noise;
      int bad;
      bad = 0;
      v4 = 1'b1; b4 = 1'b1;
      repeat (3) begin
         cyc;
         if (dv4 || rdy4) bad++;
      end
      v4 = 1'b0;
      total++; if (bad !== 0) $display("FAIL noise_idle_valid: got %0d active cycles want 0", bad); else passed++;
      run4(4'b1011, -1, 0, 1'b1);
      check_frame4("noise", 12'b11_01_10_10_01_11, 0);
   endtask

   task automatic test_random;
      logic       a, a1, a2, u;
      logic [1:0] e;
      logic [1:0] expq[$];
      int         sent, cn, nsym, err, fdn;
      bit         done;
      for (int f = 0; f < 20; f++) begin
         expq.delete();
         a1 = 1'b0; a2 = 1'b0; sent = 0; cn = 0; nsym = 0; err = 0; fdn = 0; done = 0;
         fs64 = 1'b1; v64 = 1'b0; cyc; fs64 = 1'b0;
         while (!done && cn < 400) begin
            if (sent < 64) begin
               v64 = ($urandom_range(3) != 0);
               b64 = 1'($urandom_range(1));
            end else begin
               v64 = 1'b0;
            end
            if (v64 && rdy64 && sent < 64) begin
               a = b64 ^ a1 ^ a2;
               expq.push_back({b64, a ^ a2});
               a2 = a1; a1 = a; sent++;
               if (sent == 64) begin
                  repeat (2) begin
                     u = a1 ^ a2;
                     expq.push_back({u, a2});
                     a2 = a1; a1 = 1'b0;
                  end
               end
            end
            cyc; cn++;
            if (dv64) begin
               nsym++;
               if (expq.size() == 0) err++;
               else begin
                  e = expq.pop_front();
                  if ({sys64, par64} !== e) err++;
               end
            end
            if (fd64) begin
               fdn++; done = 1;
               if (expq.size() != 0) err++;
            end
         end
         v64 = 1'b0;
         cyc;
         if (dv64 || fd64) err++;
         total++; if (err !== 0 || !done) $display("FAIL random_frame%0d_symbols: got %0d errors done=%0d want 0 errors done=1", f, err, done); else passed++;
         total++; if (nsym !== 66 || fdn !== 1) $display("FAIL random_frame%0d_count: got %0d symbols %0d done pulses want 66 and 1", f, nsym, fdn); else passed++;
         total++; if ({dut64.s1, dut64.s0} !== 2'b00) $display("FAIL random_frame%0d_end_state: got %b want 00", f, {dut64.s1, dut64.s0}); else passed++;
      end
   endtask

   initial begin
      rst = 1'b1; fs4 = 1'b0; b4 = 1'b0; v4 = 1'b0; fs64 = 1'b0; b64 = 1'b0; v64 = 1'b0;
      test_reset;
      test_basic;
      test_gap;
      test_zero;
      test_mid_reset;
      test_noise;
      test_random;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/rsc_frame_encoder.md
RSC_FRAME_ENCODER -- requirements
Module: rsc_frame_encoder

Interface
REQ-001 Parameter FRAME_LEN, default 64, meaning number of information bits per frame; legal range 1..65535.
REQ-002 Turbo_clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 frame_start  input  1  single-cycle request to open a new frame.
REQ-005 in_bit  input  1  information bit.
REQ-006 in_valid  input  1  in_bit qualifier.
REQ-007 in_ready  output  1  high when an information bit can be accepted.
REQ-008 sys  output  1  systematic bit to decoder.
REQ-009 parity  output  1  parity bit to decoder.
REQ-010 Data_Valid  output  1  sys/parity pair valid this cycle.
REQ-011 frame_done  output  1  one-cycle pulse marking the final symbol of a frame.

Function
REQ-012 Code SHALL be rate-1/2 recursive systematic convolutional, memory 2, feedback 7 (octal), feedforward 5 (octal).
REQ-013 Encoder state SHALL be two bits s1 (newest) and s0; feedback a = u ^ s1 ^ s0; parity = a ^ s0; next state s1<=a, s0<=s1.
REQ-014 FSM SHALL have states IDLE, DATA, TAIL.
REQ-015 IDLE: in_ready=0; frame_start=1 -> DATA, s1=s0=0, bit counter=0.
REQ-016 DATA: in_ready=1; accept = in_valid && in_ready; each accept advances the state per REQ-013 with u=in_bit and increments the counter.
REQ-017 DATA: in_valid=0 -> state, counter and outputs held, no symbol produced; gaps of any length allowed.
REQ-018 DATA -> TAIL on the cycle after the FRAME_LEN-th accept; in_ready SHALL be 0 in that next cycle.
REQ-019 TAIL SHALL last exactly 2 cycles; each cycle u = s1 ^ s0 (forcing a=0); sys=u, parity per REQ-013; state is 00 after the second cycle.
REQ-020 TAIL -> IDLE after the second tail cycle.
REQ-021 Outputs SHALL be registered: each accept or tail cycle yields sys/parity with Data_Valid=1 exactly one cycle later; otherwise Data_Valid=0.
REQ-022 sys and parity SHALL hold their last value while Data_Valid=0.
REQ-023 frame_done SHALL be 1 exactly in the cycle carrying the second tail symbol, otherwise 0.
REQ-024 With in_valid held high, Data_Valid SHALL be continuous for FRAME_LEN+2 cycles per frame.
REQ-025 frame_start outside IDLE SHALL be ignored; in_valid outside DATA SHALL be ignored.
REQ-026 frame_start in the same cycle the FSM enters IDLE SHALL be ignored; a new frame requires frame_start while in IDLE.
REQ-027 No downstream backpressure; symbols are never stalled or dropped once generated.

Reset
REQ-028 rst=1 at a clock edge SHALL force IDLE, s1=s0=0, counters=0, in_ready=0, sys=0, parity=0, Data_Valid=0, frame_done=0 on the next cycle.
REQ-029 rst SHALL take priority over frame_start, in_valid and all FSM transitions; reset mid-frame discards the frame with no tail and no frame_done.
REQ-030 After rst deasserts, the block SHALL remain in IDLE until frame_start.

Verification
REQ-031 FRAME_LEN=4, frame_start, then bits 1,0,1,1 back-to-back -> (sys,parity) = (1,1),(0,1),(1,0),(1,0),(0,1),(1,1) on 6 consecutive Data_Valid cycles, frame_done on the sixth only.
REQ-032 Same frame with in_valid low for 3 cycles between bits 2 and 3 -> identical symbol sequence, Data_Valid low for exactly 3 cycles, in_ready high throughout DATA.
REQ-033 FRAME_LEN=4, all-zero input -> six symbols all (0,0), state 00 at end.
REQ-034 rst asserted after the second accepted bit -> next cycle all outputs 0, IDLE; a fresh frame then encodes from state 00 and matches REQ-031.
REQ-035 frame_start pulsed during DATA and TAIL, and in_valid high during IDLE/TAIL -> no effect; symbol count per frame stays FRAME_LEN+2.
REQ-036 Random bits, FRAME_LEN=64, 20 frames -> every frame ends in state 00, outputs match a reference model, exactly one frame_done per frame.
